// File: rtl/fp_add_unit.sv
// fp_add_unit: registered adder/subtractor for a sign-magnitude float
// (1-bit sign, 4-bit unbiased exponent, 8-bit integer fraction, no hidden bit).
// Result is aligned, added, normalised and registered with one cycle latency.
module fp_add_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       sign1,
    input  logic       sign2,
    input  logic [7:0] frac1,
    input  logic [7:0] frac2,
    input  logic [3:0] exp1,
    input  logic [3:0] exp2,
    output logic       sign_out,
    output logic [7:0] frac_out,
    output logic [3:0] exp_out,
    output logic       out_valid,
    output logic       overflow
);

    logic       big_sign, small_sign;
    logic [7:0] big_frac, small_frac, small_aligned;
    logic [3:0] big_exp, exp_diff;
    logic [8:0] raw_mag;
    logic       raw_sign;
    logic [7:0] mag;
    logic [3:0] mag_exp;
    logic       sat;
    logic [3:0] lz;
    logic [3:0] norm_shift;
    logic       res_sign;
    logic [7:0] res_frac;
    logic [3:0] res_exp;
    logic       res_ovf;

    // Align, add/subtract, resolve carry, then normalise toward bit 7
    always_comb begin
        big_sign      = sign1;
        small_sign    = sign2;
        big_frac      = frac1;
        small_frac    = frac2;
        big_exp       = exp1;
        exp_diff      = exp1 - exp2;
        small_aligned = '0;
        raw_mag       = '0;
        raw_sign      = 1'b0;
        mag           = '0;
        mag_exp       = '0;
        sat           = 1'b0;
        lz            = '0;
        norm_shift    = '0;
        res_sign      = 1'b0;
        res_frac      = '0;
        res_exp       = '0;
        res_ovf       = 1'b0;

        // Operand 1 wins ties on exponent
        if (exp2 > exp1) begin
            big_sign   = sign2;
            small_sign = sign1;
            big_frac   = frac2;
            small_frac = frac1;
            big_exp    = exp2;
            exp_diff   = exp2 - exp1;
        end

        // Truncating alignment; a gap of 8 or more flushes the small operand
        if (exp_diff >= 4'd8)
            small_aligned = '0;
        else
            small_aligned = small_frac >> exp_diff[2:0];

        if (big_sign == small_sign) begin
            raw_mag  = {1'b0, big_frac} + {1'b0, small_aligned};
            raw_sign = big_sign;
        end else if (big_frac >= small_aligned) begin
            raw_mag  = {1'b0, big_frac} - {1'b0, small_aligned};
            raw_sign = big_sign;
        end else begin
            raw_mag  = {1'b0, small_aligned} - {1'b0, big_frac};
            raw_sign = small_sign;
        end

        if (raw_mag[8]) begin
            if (big_exp == 4'd15) begin
                sat     = 1'b1;
                mag     = '1;
                mag_exp = 4'd15;
            end else begin
                mag     = raw_mag[8:1];
                mag_exp = big_exp + 4'd1;
            end
        end else begin
            mag     = raw_mag[7:0];
            mag_exp = big_exp;
        end

        // Leading-zero count: the highest set bit is the last one visited
        for (int unsigned i = 0; i < 8; i++) begin
            if (mag[i])
                lz = 4'(7 - i);
        end

        // Normalisation stops at exponent 0, leaving the result unnormalised
        norm_shift = (lz > mag_exp) ? mag_exp : lz;

        if (sat) begin
            res_sign = raw_sign;
            res_frac = '1;
            res_exp  = 4'd15;
            res_ovf  = 1'b1;
        end else if (mag == 8'd0) begin
            res_sign = 1'b0;
            res_frac = '0;
            res_exp  = '0;
            res_ovf  = 1'b0;
        end else begin
            res_sign = raw_sign;
            res_frac = mag << norm_shift;
            res_exp  = mag_exp - norm_shift;
            res_ovf  = 1'b0;
        end
    end

    // Output registers: load on valid input, otherwise hold the last result
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_out  <= 1'b0;
            frac_out  <= '0;
            exp_out   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sign_out <= res_sign;
                frac_out <= res_frac;
                exp_out  <= res_exp;
                overflow <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_unit.sv
// tb_fp_add_unit: directed vectors with hand-computed results for fp_add_unit.
module tb_fp_add_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       sign1, sign2;
    logic [7:0] frac1, frac2;
    logic [3:0] exp1, exp2;
    logic       sign_out;
    logic [7:0] frac_out;
    logic [3:0] exp_out;
    logic       out_valid;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    fp_add_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sign1    (sign1),
        .sign2    (sign2),
        .frac1    (frac1),
        .frac2    (frac2),
        .exp1     (exp1),
        .exp2     (exp2),
        .sign_out (sign_out),
        .frac_out (frac_out),
        .exp_out  (exp_out),
        .out_valid(out_valid),
        .overflow (overflow)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic s, input logic [7:0] f,
                              input logic [3:0] e, input logic ov, input logic v);
        chk({tag, ".sign"},     {7'd0, sign_out},  {7'd0, s});
        chk({tag, ".frac"},     frac_out,          f);
        chk({tag, ".exp"},      {4'd0, exp_out},   {4'd0, e});
        chk({tag, ".overflow"}, {7'd0, overflow},  {7'd0, ov});
        chk({tag, ".valid"},    {7'd0, out_valid}, {7'd0, v});
    endtask

    task automatic drive(input logic v, input logic s1, input logic [7:0] f1, input logic [3:0] e1,
                         input logic s2, input logic [7:0] f2, input logic [3:0] e2);
        in_valid = v;
        sign1 = s1; frac1 = f1; exp1 = e1;
        sign2 = s2; frac2 = f2; exp2 = e2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        rst = 1'b1;
        drive(1'b1, 1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 4'($urandom));
        tick();
        expect_out("rst0", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 4'($urandom));
        tick();
        expect_out("rst1", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        rst = 1'b0;
        drive(1'b0, 1'b1, 8'hFF, 4'd9, 1'b0, 8'h12, 4'd3);
        tick();
        expect_out("idle", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        // Mixed signs, op2 bigger exponent, 3-step normalisation
        drive(1'b1, 1'b0, 8'h8F, 4'd4, 1'b1, 8'h33, 4'd5);
        tick();
        expect_out("sub_norm", 1'b0, 8'hA0, 4'd2, 1'b0, 1'b1);

        // Both negative, equal exponents
        drive(1'b1, 1'b1, 8'd52, 4'd5, 1'b1, 8'd53, 4'd5);
        tick();
        expect_out("neg_add", 1'b1, 8'hD2, 4'd4, 1'b0, 1'b1);

        // Normalisation floors at exponent 0
        drive(1'b1, 1'b0, 8'h03, 4'd4, 1'b0, 8'h02, 4'd3);
        tick();
        expect_out("norm_floor", 1'b0, 8'h40, 4'd0, 1'b0, 1'b1);

        // Carry out
        drive(1'b1, 1'b0, 8'hFF, 4'd3, 1'b0, 8'h01, 4'd3);
        tick();
        expect_out("carry", 1'b0, 8'h80, 4'd4, 1'b0, 1'b1);

        // Saturation at exponent 15
        drive(1'b1, 1'b0, 8'hFF, 4'd15, 1'b0, 8'hFF, 4'd15);
        tick();
        expect_out("saturate", 1'b0, 8'hFF, 4'd15, 1'b1, 1'b1);

        // Exact cancellation
        drive(1'b1, 1'b0, 8'h40, 4'd7, 1'b1, 8'h40, 4'd7);
        tick();
        expect_out("cancel", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);

        // Hold with in_valid low
        drive(1'b0, 1'b1, 8'h77, 4'd6, 1'b0, 8'h11, 4'd2);
        tick();
        expect_out("hold_zero", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        // Smaller-exponent-tie: op2 magnitude larger, sign follows op2
        drive(1'b1, 1'b1, 8'h20, 4'd2, 1'b0, 8'h90, 4'd2);
        tick();
        expect_out("sign_op2", 1'b0, 8'hE0, 4'd1, 1'b0, 1'b1);

        // Exponent gap of 8 flushes the small operand
        drive(1'b1, 1'b0, 8'h80, 4'd10, 1'b1, 8'hFF, 4'd2);
        tick();
        expect_out("gap8", 1'b0, 8'h80, 4'd10, 1'b0, 1'b1);

        // Negative carry near saturation keeps sign, then overflow clears
        drive(1'b1, 1'b1, 8'hFF, 4'd15, 1'b1, 8'h80, 4'd14);
        tick();
        expect_out("sat_neg", 1'b1, 8'hFF, 4'd15, 1'b1, 1'b1);

        // Back-to-back stream
        drive(1'b1, 1'b0, 8'h8F, 4'd4, 1'b1, 8'h33, 4'd5);
        tick();
        expect_out("b2b_a", 1'b0, 8'hA0, 4'd2, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'd52, 4'd5, 1'b1, 8'd53, 4'd5);
        tick();
        expect_out("b2b_b", 1'b1, 8'hD2, 4'd4, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'hFF, 4'd3, 1'b0, 8'h01, 4'd3);
        tick();
        expect_out("b2b_c", 1'b0, 8'h80, 4'd4, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 4'd0);
        tick();
        expect_out("hold_nz", 1'b0, 8'h80, 4'd4, 1'b0, 1'b0);

        // Reset overrides a valid input
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hFF, 4'd15, 1'b1, 8'hFF, 4'd15);
        tick();
        expect_out("rst_prio", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_add_unit.md
Name: fp_add_unit

Overview:
- Registered adder/subtractor for a small sign-magnitude floating-point format: 1-bit sign, 4-bit unsigned exponent, 8-bit integer fraction.
- Value = (-1)^sign × frac × 2^exp. There is no hidden bit and no exponent bias.
- Used as the arithmetic datapath block wherever two such operands are summed. Result is normalised and presented one clock after input.

Parameters:
- none; field widths are fixed (FRAC_W = 8, EXP_W = 4).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid this cycle
- sign1  input  1  operand 1 sign (1 = negative)
- sign2  input  1  operand 2 sign
- frac1  input  8  operand 1 fraction, unsigned magnitude
- frac2  input  8  operand 2 fraction
- exp1  input  4  operand 1 exponent, unsigned
- exp2  input  4  operand 2 exponent
- sign_out  output  1  result sign
- frac_out  output  8  result fraction
- exp_out  output  4  result exponent
- out_valid  output  1  result registers updated from a valid input last cycle
- overflow  output  1  result exponent saturated

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst sampled on the rising clk edge. While high, sign_out, frac_out, exp_out, out_valid and overflow are all 0.
  - rst has priority over in_valid.
- Latency and handshake:
  - Latency is exactly 1 cycle, fully pipelined, one operation per cycle accepted.
  - in_valid high at edge N: result registers load and out_valid = 1 after edge N.
  - in_valid low: out_valid = 0 next cycle; sign_out, frac_out, exp_out and overflow hold their previous values.
- Alignment:
  - The operand with the larger exponent is the "big" one. On equal exponents, operand 1 is big.
  - Result exponent starts at the big exponent. Small fraction is right-shifted by |exp1 - exp2|.
  - Shifted-out bits are truncated (no guard/round/sticky bits).
  - A difference of 8 or more makes the small fraction 0.
- Add/subtract:
  - Equal signs: 9-bit sum = aligned frac1 + aligned frac2; result sign = that common sign.
  - Different signs: subtract the smaller aligned magnitude from the larger; result sign = sign of the larger.
  - Equal aligned magnitudes with different signs give an exact zero.
- Carry out (sum ≥ 256):
  - Shift right by 1 (truncate LSB) and exponent + 1.
  - If the exponent was already 15: saturate to frac 0xFF, exp 15, overflow = 1, sign kept.
- Normalisation:
  - Nonzero results with bit 7 clear are shifted left one position per step, with exponent - 1 per step.
  - Stop when bit 7 is set or the exponent reaches 0. Exponent never wraps below 0; the result is left unnormalised at exp 0.
- Zero result: sign_out = 0, exp_out = 0, frac_out = 0, overflow = 0.
- overflow is 0 for every non-saturated valid result.
- Combinational path: alignment, add, normalise (priority encoder plus barrel shifter) feeding output registers; no multi-cycle state machine.

Test Plan:
- rst high for 2 cycles with random operands -> all outputs 0, out_valid = 0. Release rst, in_valid = 0 -> outputs remain 0.
- sign1 = 0, frac1 = 0x8F, exp1 = 4; sign2 = 1, frac2 = 0x33, exp2 = 5; in_valid = 1 -> next cycle sign_out = 0, exp_out = 2, frac_out = 0xA0, overflow = 0, out_valid = 1.
- sign1 = 1, frac1 = 52, exp1 = 5; sign2 = 1, frac2 = 53, exp2 = 5 -> sign_out = 1, exp_out = 4, frac_out = 0xD2.
- sign1 = 0, frac1 = 0x03, exp1 = 4; sign2 = 0, frac2 = 0x02, exp2 = 3 -> sign_out = 0, exp_out = 0, frac_out = 0x40 (normalisation floor at exp 0).
- Carry and saturation:
  - 0xFF exp 3 + 0x01 exp 3, both positive -> frac 0x80, exp 4.
  - 0xFF exp 15 + 0xFF exp 15 -> frac 0xFF, exp 15, overflow = 1.
- Cancellation and hold:
  - 0x40 exp 7 positive + 0x40 exp 7 negative -> sign 0, exp 0, frac 0.
  - Then in_valid = 0 -> out_valid = 0, outputs unchanged.
- Back-to-back: valid inputs on consecutive cycles -> each result appears exactly one cycle later, in order.
